dsm_decim: RTL and testbench



---
 rtl/dsm_pkg.sv | 24 ++
 rtl/cic_stage.sv | 46 ++++
 rtl/dsm_decim.sv | 133 +++++++++++++
 tb/tb_dsm_decim.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsm_pkg
// Description : Shared constants for the delta-sigma modulator and its
//               decimating demodulator (pwm codes, CIC order, sample width).
// Revision    : 1.0 - initial release
// ============================================================================
package dsm_pkg;

    // Ternary pwm line codes; 2'b10 is never produced by the modulator
    localparam logic [1:0] PWM_POS     = 2'b01;
    localparam logic [1:0] PWM_NEG     = 2'b11;
    localparam logic [1:0] PWM_ZERO    = 2'b00;
    localparam logic [1:0] PWM_ILLEGAL = 2'b10;

    // Default decimation ratio and CIC filter order
    localparam int DEF_DECIM_R = 50;
    localparam int CIC_ORDER   = 3;

    // Width of reconstructed signed samples
    localparam int SAMPLE_W = 20;

endpackage : dsm_pkg
`default_nettype wire

// File: rtl/cic_stage.sv
`default_nettype none
// ============================================================================
// Module      : cic_stage
// Description : One CIC section: a free-running integrator register and a
//               strobe-enabled comb (combinational difference + delay reg).
//               All arithmetic is modular; wrap-around is intended.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_stage #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [WIDTH-1:0] integ_in,
    output logic [WIDTH-1:0] integ_out,
    input  logic [WIDTH-1:0] comb_in,
    output logic [WIDTH-1:0] comb_out
);

    logic [WIDTH-1:0] r_integ;
    logic [WIDTH-1:0] r_delay;

    // Integrator: accumulate the upstream value every fast clock
    always_ff @(posedge clock) begin
        if (reset) begin
            r_integ <= '0;
        end else begin
            r_integ <= r_integ + integ_in;
        end
    end

    // Comb delay: remember the comb input of the previous decimated sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_delay <= '0;
        end else if (strobe) begin
            r_delay <= comb_in;
        end
    end

    assign integ_out = r_integ;
    assign comb_out  = comb_in - r_delay;

endmodule : cic_stage
`default_nettype wire

// File: rtl/dsm_decim.sv
`default_nettype none
// ============================================================================
// Module      : dsm_decim
// Description : Decimating demodulator for the ternary pwm bitstream.
//               Decodes pwm, runs a 3rd-order CIC at the fast clock rate and
//               emits scaled, saturated 20-bit samples every DECIM_R clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_decim
    import dsm_pkg::*;
#(
    parameter int DECIM_R   = DEF_DECIM_R,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 2,
    parameter int WARMUP    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          pwm,
    output logic [SAMPLE_W-1:0] vout,
    output logic                vout_valid,
    output logic                code_err
);

    localparam int c_DCNT_W = (DECIM_R > 1) ? $clog2(DECIM_R) : 1;
    localparam int c_WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    // Scaled width must hold the shifted CIC result and the saturation bounds
    localparam int c_EXT_W  = (ACC_W + OUT_SHIFT > SAMPLE_W) ? (ACC_W + OUT_SHIFT) : (SAMPLE_W + 1);
    localparam logic signed [c_EXT_W-1:0] c_SAT_MAX = c_EXT_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [c_EXT_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

    logic [ACC_W-1:0]           w_x;
    logic [ACC_W-1:0]           w_integ [CIC_ORDER+1];
    logic [ACC_W-1:0]           w_comb  [CIC_ORDER+1];
    logic signed [ACC_W-1:0]    w_c3;
    logic signed [c_EXT_W-1:0]  w_scaled;
    logic [SAMPLE_W-1:0]        w_sat;
    logic                       w_strobe;
    logic                       w_warm;
    logic [c_DCNT_W-1:0]        r_dcnt;
    logic [c_WCNT_W-1:0]        r_wcnt;

    // Decode the ternary code into a sign-extended integrator input
    always_comb begin
        w_x = '0;
        case (pwm)
            PWM_POS:  w_x = ACC_W'(1);
            PWM_NEG:  w_x = '1;
            PWM_ZERO: w_x = '0;
            default:  w_x = '0;
        endcase
    end

    // Integrators chain forward from the decoded input; combs chain from i3
    assign w_integ[0] = w_x;
    assign w_comb[0]  = w_integ[CIC_ORDER];

    generate
        for (genvar gi = 0; gi < CIC_ORDER; gi++) begin : g_stage
            cic_stage #(
                .WIDTH (ACC_W)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .strobe    (w_strobe),
                .integ_in  (w_integ[gi]),
                .integ_out (w_integ[gi+1]),
                .comb_in   (w_comb[gi]),
                .comb_out  (w_comb[gi+1])
            );
        end
    endgenerate

    // Scale the final comb output and clamp it to the sample range
    assign w_c3     = w_comb[CIC_ORDER];
    assign w_scaled = c_EXT_W'(w_c3) <<< OUT_SHIFT;

    always_comb begin
        w_sat = w_scaled[SAMPLE_W-1:0];
        if (w_scaled > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[SAMPLE_W-1:0];
        end else if (w_scaled < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[SAMPLE_W-1:0];
        end
    end

    assign w_strobe = (r_dcnt == c_DCNT_W'(DECIM_R - 1));
    assign w_warm   = (r_wcnt == c_WCNT_W'(WARMUP));

    // Decimation phase counter; strobe on the last phase of each frame
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dcnt <= '0;
        end else if (w_strobe) begin
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + c_DCNT_W'(1);
        end
    end

    // Warm-up counter: counts strobes until the comb history is filled
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if (w_strobe && !w_warm) begin
            r_wcnt <= r_wcnt + c_WCNT_W'(1);
        end
    end

    // Output register: sample updates on every strobe, valid only once warm
    always_ff @(posedge clock) begin
        if (reset) begin
            vout       <= '0;
            vout_valid <= 1'b0;
        end else begin
            vout_valid <= w_strobe && w_warm;
            if (w_strobe) begin
                vout <= w_sat;
            end
        end
    end

    // Sticky flag for the illegal line code
    always_ff @(posedge clock) begin
        if (reset) begin
            code_err <= 1'b0;
        end else if (pwm == PWM_ILLEGAL) begin
            code_err <= 1'b1;
        end
    end

endmodule : dsm_decim
`default_nettype wire

// File: tb/tb_dsm_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_decim
// Description : Directed self-checking bench for dsm_decim with hand-computed
//               expected CIC outputs (DECIM_R=50, gain 500000 per unit input).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_decim;

    logic        clock;
    logic        reset;
    logic [1:0]  pwm;
    logic [19:0] vout;
    logic        vout_valid;
    logic        code_err;

    int checks;
    int errors;

    dsm_decim u_dut (
        .clock      (clock),
        .reset      (reset),
        .pwm        (pwm),
        .vout       (vout),
        .vout_valid (vout_valid),
        .code_err   (code_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Two reset edges; the next edge is cycle 1
    task automatic do_reset();
        reset = 1'b1;
        pwm   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Input code applied at edge n for each pattern
    function automatic logic [1:0] pat(input int m, input int n);
        logic [1:0] p;
        case (m)
            0:       p = 2'b01;
            1:       p = 2'b11;
            2:       p = 2'b00;
            3:       p = (n % 2 == 1) ? 2'b01 : 2'b11;
            4:       p = (n % 2 == 1) ? 2'b01 : 2'b00;
            5:       p = (n >= 400) ? 2'b01 : 2'b00;
            default: p = (n == 500) ? 2'b10 : 2'b01;
        endcase
        return p;
    endfunction

    // Hand-computed output for the strobe at edge s (s >= 200)
    function automatic logic signed [19:0] model_out(input int m, input int s);
        logic signed [19:0] y;
        case (m)
            0: y = 20'sd500000;
            1: y = -20'sd500000;
            2: y = 20'sd0;
            3: y = 20'sd0;
            4: y = 20'sd250000;
            5: y = (s < 450) ? 20'sd0 : (s == 450) ? 20'sd78400 :
                   (s == 500) ? 20'sd411600 : 20'sd500000;
            default: y = (s == 550) ? 20'sd495296 : (s == 600) ? 20'sd494708 :
                         (s == 650) ? 20'sd499996 : 20'sd500000;
        endcase
        return y;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        pwm   = 2'b10;
        tick();
        tick();
        tick();
        checks++;
        if (vout !== 20'd0) begin
            errors++;
            $display("FAIL reset_vout: got %0d want 0", $signed(vout));
        end
        checks++;
        if (vout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", vout_valid);
        end
        checks++;
        if (code_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_code_err: got %b want 0", code_err);
        end
        reset = 1'b0;
        pwm   = 2'b00;
    endtask

    task automatic test_patterns();
        logic               exp_v;
        logic               exp_e;
        logic signed [19:0] exp_y;
        for (int m = 0; m < 7; m++) begin
            do_reset();
            for (int n = 1; n <= 720; n++) begin
                pwm = pat(m, n);
                tick();
                exp_v = (n % 50 == 0) && (n >= 200);
                exp_e = (m == 6) && (n >= 500);
                checks++;
                if (vout_valid !== exp_v) begin
                    errors++;
                    $display("FAIL pattern%0d_valid cycle %0d: got %b want %b", m, n, vout_valid, exp_v);
                end
                checks++;
                if (code_err !== exp_e) begin
                    errors++;
                    $display("FAIL pattern%0d_code_err cycle %0d: got %b want %b", m, n, code_err, exp_e);
                end
                if (n >= 200) begin
                    exp_y = model_out(m, (n / 50) * 50);
                    checks++;
                    if (vout !== exp_y) begin
                        errors++;
                        $display("FAIL pattern%0d_vout cycle %0d: got %0d want %0d", m, n, $signed(vout), exp_y);
                    end
                end
            end
        end
    endtask

    task automatic test_wraparound();
        logic exp_v;
        do_reset();
        for (int n = 1; n <= 9000; n++) begin
            pwm = 2'b01;
            tick();
            exp_v = (n % 50 == 0) && (n >= 200);
            if (n == 50) begin
                checks++;
                if (vout !== 20'd73696 || vout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL warmup_vout: got %0d/%b want 73696/0", $signed(vout), vout_valid);
                end
            end
            checks++;
            if (vout_valid !== exp_v) begin
                errors++;
                $display("FAIL wrap_valid cycle %0d: got %b want %b", n, vout_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (vout !== 20'd500000) begin
                    errors++;
                    $display("FAIL wrap_vout cycle %0d: got %0d want 500000", n, $signed(vout));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic exp_v;
        do_reset();
        for (int n = 1; n <= 329; n++) begin
            pwm = (n == 100) ? 2'b10 : 2'b01;
            tick();
        end
        checks++;
        if (code_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre_err: got %b want 1", code_err);
        end
        reset = 1'b1;
        pwm   = 2'b01;
        tick();
        checks++;
        if (vout !== 20'd0 || vout_valid !== 1'b0 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got vout=%0d valid=%b err=%b want 0/0/0",
                     $signed(vout), vout_valid, code_err);
        end
        reset = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            pwm = 2'b01;
            tick();
            exp_v = (n == 200) || (n == 250);
            checks++;
            if (vout_valid !== exp_v) begin
                errors++;
                $display("FAIL mid_reset_valid cycle %0d: got %b want %b", n, vout_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (vout !== 20'd500000) begin
                    errors++;
                    $display("FAIL mid_reset_vout cycle %0d: got %0d want 500000", n, $signed(vout));
                end
            end
        end
    endtask

    task automatic test_reset_on_strobe();
        do_reset();
        for (int n = 1; n <= 249; n++) begin
            pwm = 2'b01;
            tick();
        end
        reset = 1'b1;
        tick();
        checks++;
        if (vout_valid !== 1'b0 || vout !== 20'd0) begin
            errors++;
            $display("FAIL strobe_reset: got valid=%b vout=%0d want 0/0", vout_valid, $signed(vout));
        end
        reset = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            pwm = 2'b01;
            tick();
            checks++;
            if (vout_valid !== 1'b0) begin
                errors++;
                $display("FAIL strobe_reset_stale cycle %0d: got %b want 0", n, vout_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pwm    = 2'b00;
        test_reset();
        test_patterns();
        test_wraparound();
        test_mid_reset();
        test_reset_on_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dsm_decim
`default_nettype wire
